// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline register chain.
// The control field layout mirrors the RV32IM pipeline control bundle.
package pipe_pkg;

  // Control bundle carried alongside the payload; zeroed in empty stages.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [2:0] funct3;
    logic       is_m;
  } ctrl_t;

  localparam int unsigned CtrlW = $bits(ctrl_t);
  localparam int unsigned DataW = 32;

  // Occupancy counts stages plus an optional skid entry: 0..depth+1.
  function automatic int unsigned occ_width(int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/ctrl/data register with load, kill and hold.
// Ctrl and data are forced to zero whenever the slot holds no valid item.
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_load,
  input  logic              i_kill,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid_d
);

  logic              r_v;
  logic [CTRL_W-1:0] r_c;
  logic [DATA_W-1:0] r_d;
  logic              w_v_d;
  logic [CTRL_W-1:0] w_c_d;
  logic [DATA_W-1:0] w_d_d;

  // Next state: kill beats load, load beats hold; invalid items carry zeros.
  always_comb begin
    w_v_d = r_v;
    w_c_d = r_c;
    w_d_d = r_d;
    if (i_kill) begin
      w_v_d = 1'b0;
      w_c_d = '0;
      w_d_d = '0;
    end else if (i_load) begin
      w_v_d = i_valid;
      w_c_d = i_valid ? i_ctrl : '0;
      w_d_d = i_valid ? i_data : '0;
    end
  end

  // Slot register with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_v <= 1'b0;
      r_c <= '0;
      r_d <= '0;
    end else begin
      r_v <= w_v_d;
      r_c <= w_c_d;
      r_d <= w_d_d;
    end
  end

  assign o_valid   = r_v;
  assign o_ctrl    = r_c;
  assign o_data    = r_d;
  assign o_valid_d = w_v_d;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH slots with valid/ready handshake,
// bubble collapsing, per-stage kill and an optional input skid entry.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CtrlW,
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SKID   = 0
) (
  input  logic                              clk,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CTRL_W-1:0]                 in_ctrl,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [DEPTH-1:0]                  kill,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CTRL_W-1:0]                 out_ctrl,
  output logic [DATA_W-1:0]                 out_data,
  output logic [occ_width(DEPTH)-1:0]       occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  // Stage state and per-stage load sources.
  logic [DEPTH-1:0]             w_v;
  logic [DEPTH-1:0][CTRL_W-1:0] w_c;
  logic [DEPTH-1:0][DATA_W-1:0] w_d;
  logic [DEPTH-1:0]             w_v_d;
  logic [DEPTH-1:0]             w_src_v;
  logic [DEPTH-1:0][CTRL_W-1:0] w_src_c;
  logic [DEPTH-1:0][DATA_W-1:0] w_src_d;
  logic [DEPTH:0]               w_adv;

  // Skid entry (tied off when SKID=0).
  logic              w_skid_v;
  logic [CTRL_W-1:0] w_skid_c;
  logic [DATA_W-1:0] w_skid_d;
  logic              w_skid_v_d;

  logic              w_in_xfer;
  logic [OccW-1:0]   w_occ_d;
  logic [OccW-1:0]   r_occ;

  // Advance chain: a stage moves if it is empty or the next one moves.
  always_comb begin
    w_adv        = '0;
    w_adv[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_adv[i] = ~w_v[i] | w_adv[i+1];
    end
  end

  // While clr is high nothing is accepted, even though every stage is empty.
  assign in_ready  = ~clr & ((SKID != 0) ? ~w_skid_v : w_adv[0]);
  assign w_in_xfer = in_valid & in_ready;

  // Load sources: stage 0 prefers the skid item, later stages take upstream.
  always_comb begin
    w_src_v    = '0;
    w_src_c    = '0;
    w_src_d    = '0;
    w_src_v[0] = w_skid_v | w_in_xfer;
    w_src_c[0] = w_skid_v ? w_skid_c : in_ctrl;
    w_src_d[0] = w_skid_v ? w_skid_d : in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      w_src_v[i] = w_v[i-1];
      w_src_c[i] = w_c[i-1];
      w_src_d[i] = w_d[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .clr       (clr),
      .i_load    (w_adv[g]),
      .i_kill    (kill[g]),
      .i_valid   (w_src_v[g]),
      .i_ctrl    (w_src_c[g]),
      .i_data    (w_src_d[g]),
      .o_valid   (w_v[g]),
      .o_ctrl    (w_c[g]),
      .o_data    (w_d[g]),
      .o_valid_d (w_v_d[g])
    );
  end

  if (SKID != 0) begin : g_skid
    logic w_skid_load;
    logic w_skid_in_v;

    // Loads whenever stage 0 moves (draining to empty) or when an accepted
    // item cannot enter stage 0 this cycle (capture).
    assign w_skid_load = w_adv[0] | w_in_xfer;
    assign w_skid_in_v = w_in_xfer & ~w_adv[0];

    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk       (clk),
      .clr       (clr),
      .i_load    (w_skid_load),
      .i_kill    (kill[0]),
      .i_valid   (w_skid_in_v),
      .i_ctrl    (in_ctrl),
      .i_data    (in_data),
      .o_valid   (w_skid_v),
      .o_ctrl    (w_skid_c),
      .o_data    (w_skid_d),
      .o_valid_d (w_skid_v_d)
    );
  end else begin : g_no_skid
    assign w_skid_v   = 1'b0;
    assign w_skid_c   = '0;
    assign w_skid_d   = '0;
    assign w_skid_v_d = 1'b0;
  end

  // Next occupancy is the count of items that will be held after the edge;
  // this covers accepts, out-transfers and kills in one term and cannot wrap.
  always_comb begin
    w_occ_d = OccW'(w_skid_v_d);
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_occ_d = w_occ_d + OccW'(w_v_d[i]);
    end
  end

  // Registered occupancy counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_d;
    end
  end

  assign occupancy = r_occ;
  assign out_valid = w_v[DEPTH-1];
  assign out_ctrl  = w_c[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a directed vector table on the SKID=0 instance,
// hand sequences for skid fill and mid-stream clear, then random traffic on
// both SKID=0 and SKID=1 instances against an item-movement reference model.
module tb_pipe_stage_chain;

  localparam int D = 2;

  logic        clk;
  logic        clr;
  logic        iv  [2];
  logic        ir  [2];
  logic [7:0]  ic  [2];
  logic [31:0] id  [2];
  logic [1:0]  kl  [2];
  logic        ov  [2];
  logic        orr [2];
  logic [7:0]  oc  [2];
  logic [31:0] od  [2];
  logic [1:0]  occ [2];

  int n_tests;
  int n_fail;

  pipe_stage_chain #(.CTRL_W(8), .DATA_W(32), .DEPTH(D), .SKID(0)) u_dut0 (
    .clk(clk), .clr(clr), .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ic[0]),
    .in_data(id[0]), .kill(kl[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0])
  );

  pipe_stage_chain #(.CTRL_W(8), .DATA_W(32), .DEPTH(D), .SKID(1)) u_dut1 (
    .clk(clk), .clr(clr), .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ic[1]),
    .in_data(id[1]), .kill(kl[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: items moving through slots ----------
  bit          mv [2][D];
  logic [7:0]  mc [2][D];
  logic [31:0] md [2][D];
  bit          sv [2];
  logic [7:0]  sc [2];
  logic [31:0] sd [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) begin
        mv[k][i] = 0; mc[k][i] = '0; md[k][i] = '0;
      end
      sv[k] = 0; sc[k] = '0; sd[k] = '0;
    end
  endtask

  // Returns pre-edge expectations for instance k and advances its state.
  task automatic model_cycle(input int k, output bit e_ov, output logic [7:0] e_oc,
                             output logic [31:0] e_od, output bit e_ir, output int e_occ);
    bit          nv [D];
    logic [7:0]  nc [D];
    logic [31:0] nd [D];
    bit          nsv, free0, acc;
    logic [7:0]  nsc;
    logic [31:0] nsd;
    e_ov  = mv[k][D-1];
    e_oc  = mv[k][D-1] ? mc[k][D-1] : 8'h0;
    e_od  = mv[k][D-1] ? md[k][D-1] : 32'h0;
    e_occ = int'(sv[k]);
    for (int i = 0; i < D; i++) begin
      e_occ += int'(mv[k][i]);
      nv[i] = mv[k][i]; nc[i] = mc[k][i]; nd[i] = md[k][i];
    end
    nsv = sv[k]; nsc = sc[k]; nsd = sd[k];
    // consumer takes the head item, then items slide into free slots
    if (nv[D-1] && orr[k]) begin
      nv[D-1] = 0; nc[D-1] = '0; nd[D-1] = '0;
    end
    for (int i = D - 2; i >= 0; i--) begin
      if (nv[i] && !nv[i+1]) begin
        nv[i+1] = 1; nc[i+1] = nc[i]; nd[i+1] = nd[i];
        nv[i] = 0; nc[i] = '0; nd[i] = '0;
      end
    end
    free0 = !nv[0];
    e_ir  = (k == 1) ? !sv[k] : free0;
    acc   = iv[k] && e_ir;
    if (k == 1) begin
      if (free0) begin
        if (nsv) begin
          nv[0] = 1; nc[0] = nsc; nd[0] = nsd;
          nsv = 0; nsc = '0; nsd = '0;
        end else if (acc) begin
          nv[0] = 1; nc[0] = ic[k]; nd[0] = id[k];
        end
      end else if (acc) begin
        nsv = 1; nsc = ic[k]; nsd = id[k];
      end
    end else if (acc) begin
      nv[0] = 1; nc[0] = ic[k]; nd[0] = id[k];
    end
    // kills apply to whatever lands in each slot after the moves
    for (int i = 0; i < D; i++) begin
      if (kl[k][i]) begin
        nv[i] = 0; nc[i] = '0; nd[i] = '0;
      end
    end
    if (k == 1 && kl[k][0]) begin
      nsv = 0; nsc = '0; nsd = '0;
    end
    for (int i = 0; i < D; i++) begin
      mv[k][i] = nv[i]; mc[k][i] = nc[i]; md[k][i] = nd[i];
    end
    sv[k] = nsv; sc[k] = nsc; sd[k] = nsd;
  endtask

  // ---------------- directed vector table (SKID=0 instance) --------------
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic [1:0]  k;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic [1:0] k,
                              logic e_ov, logic [31:0] e_od, logic e_ir, logic [1:0] e_occ);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.k = k;
    t.e_ov = e_ov; t.e_od = e_od; t.e_ir = e_ir; t.e_occ = e_occ;
    return t;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ic[k] = '0; id[k] = '0; kl[k] = '0; orr[k] = 1;
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    clr = 1;
    repeat (2) @(negedge clk);
    clr = 0;
    model_reset();
  endtask

  initial begin
    vec_t        tv [21];
    logic [31:0] got [$];
    logic [31:0] exp_s [3];
    bit          e_ov, e_ir;
    logic [7:0]  e_oc;
    logic [31:0] e_od;
    int          e_occ, lat;

    n_tests = 0;
    n_fail  = 0;
    clr     = 0;
    idle_inputs();
    #1 clr = 1;
    #1;
    check("reset_out_valid", ov[0], 0);
    check("reset_in_ready", ir[0], 0);
    check("reset_occupancy", occ[0], 0);
    check("reset_skid_in_ready", ir[1], 0);
    apply_reset();

    // stream, stall, bubble collapse, kill
    tv[0]  = mk(1, 32'h1,  1, 2'b00, 0, 0,      1, 0);
    tv[1]  = mk(1, 32'h2,  1, 2'b00, 0, 0,      1, 1);
    tv[2]  = mk(1, 32'h3,  1, 2'b00, 1, 32'h1,  1, 2);
    tv[3]  = mk(0, 32'h0,  1, 2'b00, 1, 32'h2,  1, 2);
    tv[4]  = mk(0, 32'h0,  1, 2'b00, 1, 32'h3,  1, 1);
    tv[5]  = mk(1, 32'hA1, 0, 2'b00, 0, 0,      1, 0);
    tv[6]  = mk(1, 32'hB2, 0, 2'b00, 0, 0,      1, 1);
    tv[7]  = mk(1, 32'hC3, 0, 2'b00, 1, 32'hA1, 0, 2);
    tv[8]  = mk(1, 32'hC3, 0, 2'b00, 1, 32'hA1, 0, 2);
    tv[9]  = mk(1, 32'hC3, 0, 2'b00, 1, 32'hA1, 0, 2);
    tv[10] = mk(0, 32'h0,  1, 2'b00, 1, 32'hA1, 1, 2);
    tv[11] = mk(0, 32'h0,  1, 2'b00, 1, 32'hB2, 1, 1);
    tv[12] = mk(1, 32'hD1, 0, 2'b00, 0, 0,      1, 0);
    tv[13] = mk(0, 32'h0,  0, 2'b00, 0, 0,      1, 1);
    tv[14] = mk(1, 32'hD3, 0, 2'b00, 1, 32'hD1, 1, 1);
    tv[15] = mk(0, 32'h0,  0, 2'b00, 1, 32'hD1, 0, 2);
    tv[16] = mk(0, 32'h0,  1, 2'b00, 1, 32'hD1, 1, 2);
    tv[17] = mk(0, 32'h0,  1, 2'b00, 1, 32'hD3, 1, 1);
    tv[18] = mk(1, 32'hE1, 1, 2'b00, 0, 0,      1, 0);
    tv[19] = mk(0, 32'h0,  1, 2'b10, 0, 0,      1, 1);
    tv[20] = mk(0, 32'h0,  1, 2'b00, 0, 0,      1, 0);

    for (int n = 0; n < 21; n++) begin
      iv[0] = tv[n].v; ic[0] = 8'h11; id[0] = tv[n].d; orr[0] = tv[n].r; kl[0] = tv[n].k;
      #1;
      check($sformatf("vec%0d_out_valid", n), ov[0], tv[n].e_ov);
      check($sformatf("vec%0d_out_data", n), od[0], tv[n].e_od);
      check($sformatf("vec%0d_out_ctrl", n), oc[0], tv[n].e_ov ? 8'h11 : 8'h00);
      check($sformatf("vec%0d_in_ready", n), ir[0], tv[n].e_ir);
      check($sformatf("vec%0d_occupancy", n), occ[0], tv[n].e_occ);
      @(negedge clk);
    end
    idle_inputs();

    // skid: fill the stages with out_ready low, one more item goes to the skid
    apply_reset();
    orr[1] = 0; iv[1] = 1; ic[1] = 8'h22;
    id[1] = 32'h51; @(negedge clk);
    id[1] = 32'h52; @(negedge clk);
    id[1] = 32'h5D; #1;
    check("skid_accept_when_full", ir[1], 1);
    check("skid_occ_before", occ[1], 2);
    @(negedge clk);
    id[1] = 32'h5E; #1;
    check("skid_in_ready_low", ir[1], 0);
    check("skid_occ_full", occ[1], 3);
    check("skid_head_held", od[1], 32'h51);
    @(negedge clk);
    iv[1] = 0; orr[1] = 1;
    exp_s = '{32'h51, 32'h52, 32'h5D};
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ov[1]) got.push_back(od[1]);
      @(negedge clk);
    end
    check("skid_drain_count", got.size(), 3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("skid_drain%0d", j), (j < got.size()) ? got[j] : 32'hx, exp_s[j]);
    end

    // asynchronous clear in the middle of a stream
    apply_reset();
    iv[0] = 1; ic[0] = 8'h33; orr[0] = 1;
    for (int c = 0; c < 3; c++) begin
      id[0] = 32'h70 + c;
      @(negedge clk);
    end
    #2 clr = 1;
    #1;
    check("clr_out_valid", ov[0], 0);
    check("clr_out_ctrl", oc[0], 0);
    check("clr_occupancy", occ[0], 0);
    check("clr_in_ready", ir[0], 0);
    @(negedge clk);
    clr = 0;
    id[0] = 32'h9;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      iv[0] = 0;
      if (ov[0]) begin
        lat = c;
        break;
      end
    end
    check("clr_release_latency", lat, D);
    check("clr_release_data", od[0], 32'h9);
    @(negedge clk);

    // random traffic on both instances against the model
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]  = ($urandom_range(0, 9) < 7);
        orr[k] = ($urandom_range(0, 9) < 6);
        ic[k]  = 8'($urandom);
        id[k]  = $urandom;
        kl[k]  = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        model_cycle(k, e_ov, e_oc, e_od, e_ir, e_occ);
        check($sformatf("rnd%0d_c%0d_out_valid", k, cyc), ov[k], e_ov);
        check($sformatf("rnd%0d_c%0d_out_data", k, cyc), od[k], e_od);
        check($sformatf("rnd%0d_c%0d_out_ctrl", k, cyc), oc[k], e_oc);
        check($sformatf("rnd%0d_c%0d_in_ready", k, cyc), ir[k], e_ir);
        check($sformatf("rnd%0d_c%0d_occupancy", k, cyc), occ[k], e_occ);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
